// File: rtl/mesh_arb_pkg.sv
// Shared types and helpers for the mesh terminal injection arbiter.
package mesh_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } arb_state_e;

    localparam int PCKG_SZ_DEF = 40;

    // A single requester still gets a 1-bit grant index so ports never collapse to zero width.
    function automatic int grant_id_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first pending request at or after rr_ptr, wrapping.
module rr_arbiter
    import mesh_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]                 req,
    input  logic [grant_id_w(NREQ)-1:0]     rr_ptr,
    input  logic                            enable,
    output logic [NREQ-1:0]                 grant,
    output logic [grant_id_w(NREQ)-1:0]     idx,
    output logic                            any_req
);

    localparam int IW = grant_id_w(NREQ);

    logic found;

    // Upper pass covers rr_ptr..NREQ-1; the lower pass only wins when nothing above was pending.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i] && (IW'(i) >= rr_ptr)) begin
                found = 1'b1;
                idx   = IW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i]) begin
                found = 1'b1;
                idx   = IW'(i);
            end
        end
    end

    always_comb begin
        grant = '0;
        for (int i = 0; i < NREQ; i++) begin
            grant[i] = enable && found && (idx == IW'(i));
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/mesh_term_inject_arb.sv
// Round-robin injection arbiter feeding one bus_mesh terminal from NREQ source FIFOs.
// Optional per-requester grant counters: define MESH_INJECT_ARB_STATS_EN.
module mesh_term_inject_arb
    import mesh_arb_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int PCKG_SZ     = PCKG_SZ_DEF,
    parameter int STALL_LIMIT = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NREQ-1:0]               req_pndng,
    input  logic [NREQ*PCKG_SZ-1:0]       req_data,
    output logic [NREQ-1:0]               req_pop,
    output logic                          pndng_i_in,
    output logic [PCKG_SZ-1:0]            data_out_i_in,
    input  logic                          popin,
    output logic [grant_id_w(NREQ)-1:0]   grant_id,
    output logic                          busy,
    output logic                          stall_err,
    output logic                          proto_err
`ifdef MESH_INJECT_ARB_STATS_EN
    ,
    output logic [NREQ*16-1:0]            grant_cnt
`endif
);

    localparam int IW = grant_id_w(NREQ);
    localparam int SW = $clog2(STALL_LIMIT + 1);

    // Handshake: pndng_i_in is valid, popin is ready; a packet moves on a cycle where both are
    // high, and the offered data never changes while pndng_i_in is high without popin.
    arb_state_e          state_q, state_d;
    logic [PCKG_SZ-1:0]  hold_q;
    logic [IW-1:0]       gid_q, ptr_q, win_idx, ptr_next;
    logic [SW-1:0]       stall_q;
    logic                stall_err_q, proto_err_q;
    logic                cap_en, capture, any_req;

    // A capture slot opens in IDLE, or in OFFER when the held packet leaves this cycle.
    assign cap_en  = reset && ((state_q == IDLE) || popin);
    assign capture = cap_en && any_req;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req     (req_pndng),
        .rr_ptr  (ptr_q),
        .enable  (cap_en),
        .grant   (req_pop),
        .idx     (win_idx),
        .any_req (any_req)
    );

    assign ptr_next = (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + IW'(1);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = OFFER;
            OFFER:   if (popin && !any_req) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            hold_q  <= '0;
            gid_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                hold_q <= req_data[int'(win_idx)*PCKG_SZ +: PCKG_SZ];
                gid_q  <= win_idx;
                ptr_q  <= ptr_next;
            end
        end
    end

    // The stall counter saturates; the packet stays offered, only the sticky flag reports it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q     <= '0;
            stall_err_q <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            if (state_q == OFFER) begin
                if (popin) begin
                    stall_q <= '0;
                end else if (stall_q != SW'(STALL_LIMIT)) begin
                    stall_q <= stall_q + SW'(1);
                    if (stall_q == SW'(STALL_LIMIT - 1)) stall_err_q <= 1'b1;
                end
            end
            if (popin && state_q == IDLE) proto_err_q <= 1'b1;
        end
    end

    // busy mirrors the FSM state directly.
    assign busy          = (state_q == OFFER);
    assign pndng_i_in    = (state_q == OFFER);
    assign data_out_i_in = hold_q;
    assign grant_id      = gid_q;
    assign stall_err     = stall_err_q;
    assign proto_err     = proto_err_q;

`ifdef MESH_INJECT_ARB_STATS_EN
    logic [15:0] cnt_q [NREQ];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_pop[i] && cnt_q[i] != 16'hFFFF) cnt_q[i] <= cnt_q[i] + 16'd1;
            end
        end
    end

    always_comb begin
        grant_cnt = '0;
        for (int i = 0; i < NREQ; i++) grant_cnt[i*16 +: 16] = cnt_q[i];
    end
`endif

endmodule

// File: tb/tb_mesh_term_inject_arb.sv
// Directed-vector bench for mesh_term_inject_arb (NREQ=4, PCKG_SZ=40, STALL_LIMIT=8).
module tb_mesh_term_inject_arb;

    localparam int NREQ = 4;
    localparam int PW   = 40;

    logic            clk;
    logic            reset;
    logic [NREQ-1:0] req_pndng;
    logic [NREQ*PW-1:0] req_data;
    logic [NREQ-1:0] req_pop;
    logic            pndng_i_in;
    logic [PW-1:0]   data_out_i_in;
    logic            popin;
    logic [1:0]      grant_id;
    logic            busy, stall_err, proto_err;
`ifdef MESH_INJECT_ARB_STATS_EN
    logic [NREQ*16-1:0] grant_cnt;
`endif

    int vectors = 0;
    int errors  = 0;

    mesh_term_inject_arb #(.NREQ(NREQ), .PCKG_SZ(PW), .STALL_LIMIT(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_pndng     (req_pndng),
        .req_data      (req_data),
        .req_pop       (req_pop),
        .pndng_i_in    (pndng_i_in),
        .data_out_i_in (data_out_i_in),
        .popin         (popin),
        .grant_id      (grant_id),
        .busy          (busy),
        .stall_err     (stall_err),
        .proto_err     (proto_err)
`ifdef MESH_INJECT_ARB_STATS_EN
        ,
        .grant_cnt     (grant_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [PW-1:0] pkt(input int i);
        return 40'h11_2233_4400 + PW'(i) * 40'h01_0000_0011;
    endfunction

    task automatic load_pkts();
        for (int i = 0; i < NREQ; i++) req_data[i*PW +: PW] = pkt(i);
    endtask

    // Leaves the bench 1 time unit after a rising edge with reset released.
    task automatic do_reset();
        reset = 1'b0; req_pndng = '0; popin = 1'b0; load_pkts();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; req_pndng = 4'b1111; popin = 1'b0; load_pkts();
        #7;
        vectors++; if (pndng_i_in !== 1'b0) begin errors++; $display("FAIL reset_pndng: got %b want 0", pndng_i_in); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (req_pop !== 4'b0000) begin errors++; $display("FAIL reset_req_pop: got %b want 0000", req_pop); end
        vectors++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
        vectors++; if ({stall_err, proto_err} !== 2'b00) begin errors++; $display("FAIL reset_errs: got %b want 00", {stall_err, proto_err}); end
        vectors++; if (data_out_i_in !== 40'h0) begin errors++; $display("FAIL reset_data: got %h want 0", data_out_i_in); end
    endtask

    task automatic test_single_source();
        do_reset();
        req_data[0 +: PW] = 40'hAA_0000_0001;
        req_pndng = 4'b0001;
        #1;
        vectors++; if (req_pop !== 4'b0001) begin errors++; $display("FAIL single_pop: got %b want 0001", req_pop); end
        vectors++; if (pndng_i_in !== 1'b0) begin errors++; $display("FAIL single_pre_pndng: got %b want 0", pndng_i_in); end
        next_cycle();
        req_pndng = 4'b0000;
        #1;
        for (int c = 0; c < 3; c++) begin
            vectors++; if (pndng_i_in !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL single_offer c%0d: got pndng=%b busy=%b want 1 1", c, pndng_i_in, busy); end
            vectors++; if (data_out_i_in !== 40'hAA_0000_0001) begin errors++; $display("FAIL single_data c%0d: got %h want aa00000001", c, data_out_i_in); end
            vectors++; if (req_pop !== 4'b0000) begin errors++; $display("FAIL single_no_repop c%0d: got %b want 0000", c, req_pop); end
            next_cycle();
        end
        vectors++; if (grant_id !== 2'd0) begin errors++; $display("FAIL single_gid: got %0d want 0", grant_id); end
        popin = 1'b1;
        next_cycle();
        popin = 1'b0;
        #1;
        vectors++; if (pndng_i_in !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_idle: got pndng=%b busy=%b want 0 0", pndng_i_in, busy); end
        vectors++; if (proto_err !== 1'b0) begin errors++; $display("FAIL single_proto: got %b want 0", proto_err); end
    endtask

    task automatic test_fairness();
        logic [NREQ-1:0] exp_pop;
        do_reset();
        req_pndng = 4'b1111;
        #1;
        vectors++; if (req_pop !== 4'b0001) begin errors++; $display("FAIL fair_first_pop: got %b want 0001", req_pop); end
        next_cycle();
        popin = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            #1;
            exp_pop = 4'b0001 << (k % 4);
            vectors++; if (pndng_i_in !== 1'b1) begin errors++; $display("FAIL fair_gap k%0d: got %b want 1", k, pndng_i_in); end
            vectors++; if (grant_id !== 2'((k - 1) % 4)) begin errors++; $display("FAIL fair_gid k%0d: got %0d want %0d", k, grant_id, (k - 1) % 4); end
            vectors++; if (data_out_i_in !== pkt((k - 1) % 4)) begin errors++; $display("FAIL fair_data k%0d: got %h want %h", k, data_out_i_in, pkt((k - 1) % 4)); end
            vectors++; if (req_pop !== exp_pop) begin errors++; $display("FAIL fair_pop k%0d: got %b want %b", k, req_pop, exp_pop); end
            next_cycle();
        end
        req_pndng = 4'b0000;
        next_cycle();
        popin = 1'b0;
        #1;
        vectors++; if (pndng_i_in !== 1'b0) begin errors++; $display("FAIL fair_drain: got %b want 0", pndng_i_in); end
    endtask

    task automatic test_wrap();
        do_reset();
        req_pndng = 4'b0100;
        next_cycle();
        req_pndng = 4'b0010;
        popin = 1'b1;
        #1;
        vectors++; if (grant_id !== 2'd2) begin errors++; $display("FAIL wrap_first_gid: got %0d want 2", grant_id); end
        vectors++; if (req_pop !== 4'b0010) begin errors++; $display("FAIL wrap_pop: got %b want 0010", req_pop); end
        next_cycle();
        req_pndng = 4'b1110;
        #1;
        vectors++; if (grant_id !== 2'd1 || data_out_i_in !== pkt(1)) begin errors++; $display("FAIL wrap_gid: got %0d/%h want 1/%h", grant_id, data_out_i_in, pkt(1)); end
        vectors++; if (req_pop !== 4'b0100) begin errors++; $display("FAIL wrap_ptr2: got %b want 0100", req_pop); end
        next_cycle();
        req_pndng = 4'b0000;
        next_cycle();
        popin = 1'b0;
    endtask

    task automatic test_stall();
        do_reset();
        req_pndng = 4'b1000;
        next_cycle();
        req_pndng = 4'b0000;
        vectors++; if (stall_err !== 1'b0 || pndng_i_in !== 1'b1) begin errors++; $display("FAIL stall_start: got err=%b pndng=%b want 0 1", stall_err, pndng_i_in); end
        for (int c = 1; c <= 8; c++) begin
            next_cycle();
            vectors++; if (stall_err !== (c == 8)) begin errors++; $display("FAIL stall_err c%0d: got %b want %b", c, stall_err, (c == 8)); end
        end
        repeat (3) next_cycle();
        vectors++; if (pndng_i_in !== 1'b1 || data_out_i_in !== pkt(3)) begin errors++; $display("FAIL stall_hold: got %b/%h want 1/%h", pndng_i_in, data_out_i_in, pkt(3)); end
        popin = 1'b1;
        next_cycle();
        popin = 1'b0;
        #1;
        vectors++; if (pndng_i_in !== 1'b0 || stall_err !== 1'b1) begin errors++; $display("FAIL stall_done: got pndng=%b err=%b want 0 1", pndng_i_in, stall_err); end
    endtask

    task automatic test_proto_reset();
        do_reset();
        popin = 1'b1;
        #1;
        vectors++; if (req_pop !== 4'b0000) begin errors++; $display("FAIL proto_pop: got %b want 0000", req_pop); end
        next_cycle();
        popin = 1'b0;
        vectors++; if (proto_err !== 1'b1 || pndng_i_in !== 1'b0) begin errors++; $display("FAIL proto_err: got err=%b pndng=%b want 1 0", proto_err, pndng_i_in); end
        do_reset();
        req_pndng = 4'b0100;
        next_cycle();
        req_pndng = 4'b1111;
        vectors++; if (busy !== 1'b1 || grant_id !== 2'd2) begin errors++; $display("FAIL rst_pre: got busy=%b gid=%0d want 1 2", busy, grant_id); end
        #2 reset = 1'b0;
        #1;
        vectors++; if ({pndng_i_in, busy, grant_id} !== 4'b0000) begin errors++; $display("FAIL rst_mid_offer: got %b want 0000", {pndng_i_in, busy, grant_id}); end
        vectors++; if (req_pop !== 4'b0000) begin errors++; $display("FAIL rst_pop: got %b want 0000", req_pop); end
        next_cycle();
        reset = 1'b1;
        #1;
        vectors++; if (req_pop !== 4'b0001) begin errors++; $display("FAIL rst_restart: got %b want 0001", req_pop); end
        req_pndng = 4'b0000;
    endtask

`ifdef MESH_INJECT_ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        req_pndng = 4'b0100;
        next_cycle();
        popin = 1'b1;
        repeat (4) next_cycle();
        req_pndng = 4'b0000;
        next_cycle();
        popin = 1'b0;
        #1;
        vectors++; if (grant_cnt[2*16 +: 16] !== 16'd5) begin errors++; $display("FAIL stats_cnt2: got %0d want 5", grant_cnt[2*16 +: 16]); end
        vectors++; if ({grant_cnt[3*16 +: 16], grant_cnt[16 +: 16], grant_cnt[0 +: 16]} !== 48'h0) begin errors++; $display("FAIL stats_others: got %h want 0", grant_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_source();
        test_fairness();
        test_wrap();
        test_stall();
        test_proto_reset();
`ifdef MESH_INJECT_ARB_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
